// File: rtl/aes_pkg.sv
// Shared AES datapath definitions: block/column/byte widths, the round-unit
// FSM encoding and the helper that maps a column number onto its slot in a
// packed column array.
package aes_pkg;

  localparam int AES_BLOCK_W   = 128;
  localparam int AES_COL_W     = 32;
  localparam int AES_BYTE_W    = 8;
  localparam int AES_NUM_COLS  = AES_BLOCK_W / AES_COL_W;
  localparam int AES_COL_BYTES = AES_COL_W / AES_BYTE_W;
  localparam int AES_NUM_BYTES = AES_BLOCK_W / AES_BYTE_W;

  // Column counter width and its terminal value.
  localparam int               AES_COL_IDX_W = 2;
  localparam logic [AES_COL_IDX_W-1:0] AES_LAST_COL = 2'd3;

  typedef logic [AES_COL_W-1:0]                    aes_col_t;
  // Packed view of a block as columns. Column 0 occupies the top 32 bits, so
  // column c lives in packed slot (AES_NUM_COLS-1-c).
  typedef logic [AES_NUM_COLS-1:0][AES_COL_W-1:0]  aes_cols_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } aes_state_e;

  // Packed slot of column c: 3 - c, which for a 2-bit index is ~c.
  function automatic logic [AES_COL_IDX_W-1:0] col_slot(input logic [AES_COL_IDX_W-1:0] col);
    return ~col;
  endfunction

endpackage

// File: rtl/inv_sbox.sv
// FIPS-197 inverse S-box: purely combinational 256-entry byte lookup.
module inv_sbox
  import aes_pkg::*;
(
  input  logic [AES_BYTE_W-1:0] byte_in,
  output logic [AES_BYTE_W-1:0] byte_out
);

  localparam logic [AES_BYTE_W-1:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  assign byte_out = INV_SBOX[byte_in];

endmodule

// File: rtl/inv_sub_byte.sv
// AES-128 InvSubBytes with valid/ready handshakes on both sides.
// Default build: one 32-bit column per cycle through four inv_sbox lookups
// (4 BUSY cycles). Define INV_SUB_BYTE_PARALLEL_EN for sixteen lookups and
// a single BUSY cycle. Handshake behaviour and reset values are identical in
// both builds; only latency differs.
module inv_sub_byte
  import aes_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_BLOCK_W-1:0] data_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_BLOCK_W-1:0] data_out
);

  aes_state_e               state_q, state_d;
  logic [AES_COL_IDX_W-1:0] col_q, col_d;
  logic [AES_BLOCK_W-1:0]   in_q;
  aes_cols_t                out_q;
  logic                     accept;

  // Handshake outputs depend only on registered state (and rst).
  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign accept    = in_valid && in_ready;
  assign data_out  = out_q;

`ifdef INV_SUB_BYTE_PARALLEL_EN
  logic [AES_BLOCK_W-1:0] sub_all;

  for (genvar b = 0; b < AES_NUM_BYTES; b++) begin : g_sbox
    inv_sbox u_inv_sbox (
      .byte_in  (in_q[b*AES_BYTE_W +: AES_BYTE_W]),
      .byte_out (sub_all[b*AES_BYTE_W +: AES_BYTE_W])
    );
  end
`else
  aes_cols_t in_cols;
  aes_col_t  cur_col;
  aes_col_t  sub_col;

  assign in_cols = in_q;
  assign cur_col = in_cols[col_slot(col_q)];

  for (genvar b = 0; b < AES_COL_BYTES; b++) begin : g_sbox
    inv_sbox u_inv_sbox (
      .byte_in  (cur_col[b*AES_BYTE_W +: AES_BYTE_W]),
      .byte_out (sub_col[b*AES_BYTE_W +: AES_BYTE_W])
    );
  end
`endif

  // Next-state and column-counter logic.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave it unassigned and infer a latch.
    state_d = state_q;
    col_d   = col_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = BUSY;
          col_d   = '0;
        end
      end
      BUSY: begin
`ifdef INV_SUB_BYTE_PARALLEL_EN
        state_d = DONE;
`else
        col_d = col_q + 2'd1;
        if (col_q == AES_LAST_COL) begin
          state_d = DONE;
        end
`endif
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state and column counter registers.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (rst) begin
      state_q <= IDLE;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
    end
  end

  // Input capture on accept; result columns written while BUSY.
  always_ff @(posedge clk) begin
    // NOTE: the wide data registers are reset too, because the result must
    // read as zero after reset rather than leaking the aborted block.
    if (rst) begin
      in_q  <= '0;
      out_q <= '0;
    end else begin
      if (accept) begin
        in_q <= data_in;
      end
      if (state_q == BUSY) begin
`ifdef INV_SUB_BYTE_PARALLEL_EN
        out_q <= sub_all;
`else
        out_q[col_slot(col_q)] <= sub_col;
`endif
      end
    end
  end

endmodule

// File: doc/inv_sub_byte.md
# inv_sub_byte

Sequential AES-128 InvSubBytes unit for the decryption datapath: applies the inverse S-box to all 16 bytes of a 128-bit state. It is the decrypt-side counterpart of `sub_byte`. The default build processes one 32-bit column per cycle through four `inv_sbox` lookups, trading latency for area. A valid/ready handshake on both sides lets it sit between the AddRoundKey and InvShiftRows/InvMixColumns stages under a round controller.

## Interface
- No parameters; widths are fixed by AES-128.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: `data_in` holds a block to transform.
- `in_ready` output 1: the block can accept a new input.
- `data_in` input 128: input state. Byte 0 is `[127:120]` and byte 15 is `[7:0]`. Column c is `[127-32c -: 32]`.
- `out_valid` output 1: `data_out` holds a finished result.
- `out_ready` input 1: the downstream stage accepts the result.
- `data_out` output 128: InvSubBytes(`data_in`), with the same byte order.

## Operation
- FSM states:
  - IDLE: `in_ready`=1.
  - BUSY: column counter `col` (2 bits) counts 0..3.
  - DONE: `out_valid`=1.
- IDLE -> BUSY on `in_valid & in_ready`.
  - `data_in` is captured into the input register.
  - `col` is set to 0.
- BUSY: on each edge, result column `col` = `inv_sbox` applied bytewise to input column `col`, then `col` increments.
  - BUSY -> DONE on the edge that writes column 3.
  - `col` wraps 3 -> 0.
- DONE -> IDLE on `out_valid & out_ready`.
  - `data_out` holds its value until the next block starts overwriting it.
- `in_ready` is high only in IDLE and is forced 0 while `rst` is high. There is no input acceptance in BUSY or DONE.
- `in_valid` in BUSY or DONE is ignored. The upstream stage must hold the block until `in_ready`.
- `out_ready` is ignored outside DONE. `out_valid` stays high, with `data_out` stable, until accepted; there is no timeout.
- `data_out` is only meaningful while `out_valid`=1. In BUSY, partial overwrite is permitted.
- Reset values:
  - state IDLE, `col`=0
  - `out_valid`=0
  - `data_out`=128'h0
  - input register = 0
- Reset in any state aborts the block: no `out_valid` pulse, and the result is discarded.
- Purely bytewise. No arithmetic, no carries, no X propagation. All 256 byte values are legal.

## Timing
- Accepting edge = the edge where `in_valid & in_ready`.
- Default build: `out_valid` rises after the 4th edge following the accepting edge.
  - With `out_ready` held high, the next accept is possible 1 cycle after the output handshake.
  - Throughput: 1 block per 6 cycles.
- Parallel build: `out_valid` rises after the 1st edge following the accepting edge. Throughput: 1 block per 3 cycles.
- `in_ready` and `out_valid` are pure functions of registered state (plus `rst`). There are no combinational paths from inputs to outputs.

## Configuration
- `INV_SUB_BYTE_PARALLEL_EN`, defined:
  - 16 `inv_sbox` instances; all 128 bits are transformed on the first edge after accept.
  - BUSY lasts exactly one cycle; `col` is unused and stays at 0.
- Not defined: 4 `inv_sbox` instances with the column-serial schedule above.
- Interface, reset values and handshake rules are identical in both builds. Only latency differs.

## Structure
- Shared package `aes_pkg` holds:
  - `AES_BLOCK_W`=128, `AES_COL_W`=32, `AES_BYTE_W`=8
  - FSM state typedef/encodings (IDLE, BUSY, DONE)
  - column-slice helper constants
- Sub-module `inv_sbox`: 8-bit in, 8-bit out, combinational 256-entry FIPS-197 inverse S-box ROM. It is instantiated 4× (default) or 16× (parallel).
- Top contains the FSM, the `col` counter, the input register and the result register.

## Test plan
- In 637c777bf26b6fc53001672bfed7ab76 with `out_ready`=1 -> `data_out` 000102030405060708090a0b0c0d0e0f.
  - `out_valid` asserts exactly 4 edges after accept (1 edge in the parallel build).
- All-00 in -> 52 repeated ×16. All-FF in -> 7d repeated ×16.
  - Also run back-to-back with `in_valid` held high; verify the 6-cycle accept spacing.
- Hold `out_ready`=0 for 10 cycles in DONE:
  - `out_valid` and `data_out` stay stable; `in_ready` stays 0.
  - A new `in_valid` block is not accepted until 1 cycle after `out_ready`=1.
- Assert `rst` during BUSY (after the column 1 write):
  - Next cycle: `out_valid`=0, `data_out`=0, state IDLE.
  - A following block completes correctly.
- Round-trip with `sub_byte`:
  - 1000 random 128-bit vectors through `sub_byte` then `inv_sub_byte` -> output equals original.
  - Exhaustive per-byte check of all 256 `inv_sbox` values.
